// File: rtl/cuasi_operand_loader.sv
// Operand loader for the 4-bit quasi-ALU: collects opcode, A and B from a nibble stream and
// presents {sel, a, b} with valid/ready. Optional opcode range check via CUASI_OPCODE_CHECK_EN.
module cuasi_operand_loader #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 4,
  parameter int OP_MAX = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  txn_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_A   = 2'd1,
    GET_B   = 2'd2,
    PRESENT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0]   a_tmp_q, a_tmp_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    txn_cnt_q, txn_cnt_d;
  logic                in_xfer;
  logic                op_legal;
  logic [SEL_W+DATA_W-1:0] op_ext;

`ifdef CUASI_OPCODE_CHECK_EN
  localparam logic [DATA_W-1:0] OP_MAX_V = DATA_W'(OP_MAX);
  logic err_q, err_d;
  assign op_legal = (in_data <= OP_MAX_V);
  assign err      = err_q;
`else
  assign op_legal = 1'b1;
  assign err      = 1'b0;
`endif

  assign in_ready  = rst_n && (state_q != PRESENT);
  assign in_xfer   = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign a         = a_q;
  assign b         = b_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign txn_cnt   = txn_cnt_q;

  // Zero-extend first, then keep the low SEL_W bits: covers both SEL_W >= DATA_W and SEL_W < DATA_W.
  assign op_ext = {{SEL_W{1'b0}}, op_q};

  always_comb begin
    // NOTE: every _d is given its hold value first so no path through the case leaves it unassigned (no latches).
    state_d     = state_q;
    op_d        = op_q;
    a_tmp_d     = a_tmp_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    txn_cnt_d   = txn_cnt_q;
`ifdef CUASI_OPCODE_CHECK_EN
    err_d       = 1'b0;
`endif

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_xfer) begin
            if (op_legal) begin
              op_d    = in_data;
              state_d = GET_A;
            end else begin
`ifdef CUASI_OPCODE_CHECK_EN
              err_d = 1'b1;
`endif
            end
          end
        end
        GET_A: begin
          if (in_xfer) begin
            a_tmp_d = in_data;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (in_xfer) begin
            sel_d       = op_ext[SEL_W-1:0];
            a_d         = a_tmp_q;
            b_d         = in_data;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
        PRESENT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            txn_cnt_d   = txn_cnt_q + CNT_W'(1);
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_tmp_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      txn_cnt_q   <= '0;
`ifdef CUASI_OPCODE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_tmp_q     <= a_tmp_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      txn_cnt_q   <= txn_cnt_d;
`ifdef CUASI_OPCODE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cuasi_operand_loader.sv
// Directed self-checking bench for cuasi_operand_loader (default parameters).
module tb_cuasi_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [3:0] a, b, sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;
  logic [7:0] txn_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cuasi_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .err      (err),
    .txn_cnt  (txn_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] nib);
    in_valid = 1'b1;
    in_data  = nib;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_bundle(input string tag, input logic [3:0] es, input logic [3:0] ea,
                              input logic [3:0] eb);
    check({tag, "_sel"}, 32'(sel), 32'(es));
    check({tag, "_a"},   32'(a),   32'(ea));
    check({tag, "_b"},   32'(b),   32'(eb));
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_txn", 32'(txn_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_bundle("rst", 4'd0, 4'd0, 4'd0);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Basic add transaction, consumed immediately.
    out_ready = 1'b1;
    send(4'd0); send(4'd8);
    check("t1_busy_getb", 32'(busy), 32'd1);
    send(4'd6);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check_bundle("t1", 4'd0, 4'd8, 4'd6);
    check("t1_txn_pre", 32'(txn_cnt), 32'd0);
    tick();
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    check("t1_txn", 32'(txn_cnt), 32'd1);
    check("t1_in_ready_back", 32'(in_ready), 32'd1);

    // Back-pressure: bundle held stable for 6 cycles, junk input ignored.
    out_ready = 1'b0;
    send(4'd1); send(4'd3); send(4'd2);
    in_valid = 1'b1; in_data = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_in_ready", 32'(in_ready), 32'd0);
      check_bundle("t2_hold", 4'd1, 4'd3, 4'd2);
      check("t2_hold_txn", 32'(txn_cnt), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    check("t2_c6_valid", 32'(out_valid), 32'd1);
    check_bundle("t2_c6", 4'd1, 4'd3, 4'd2);
    tick();
    in_valid = 1'b0;
    check("t2_release_txn", 32'(txn_cnt), 32'd2);
    check("t2_release_valid", 32'(out_valid), 32'd0);
    check("t2_release_busy", 32'(busy), 32'd0);

    // Flush in GET_B: partial transaction dropped, outputs keep old bundle.
    send(4'd0); send(4'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t3_flush_busy", 32'(busy), 32'd0);
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    check_bundle("t3_flush", 4'd1, 4'd3, 4'd2);
    check("t3_flush_txn", 32'(txn_cnt), 32'd2);
    tick();
    check("t3_idle_valid", 32'(out_valid), 32'd0);
    send(4'd0); send(4'd1); send(4'd5);
    check_bundle("t3_next", 4'd0, 4'd1, 4'd5);
    tick();
    check("t3_next_txn", 32'(txn_cnt), 32'd3);

    // Flush coinciding with an output handshake: no count.
    send(4'd0); send(4'd4); send(4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3b_flush_hs_valid", 32'(out_valid), 32'd0);
    check("t3b_flush_hs_txn", 32'(txn_cnt), 32'd3);
    check("t3b_flush_hs_busy", 32'(busy), 32'd0);

    // Reset during PRESENT.
    out_ready = 1'b0;
    send(4'd0); send(4'd10); send(4'd2);
    check_bundle("t4_pre", 4'd0, 4'd10, 4'd2);
    rst_n = 1'b0;
    #1 check("t4_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("t4_valid", 32'(out_valid), 32'd0);
    check_bundle("t4", 4'd0, 4'd0, 4'd0);
    check("t4_txn", 32'(txn_cnt), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    tick();
    check("t4_in_ready_held", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("t4_in_ready_rel", 32'(in_ready), 32'd1);
    tick();

    // 256 back-to-back transactions; in_valid asserted in PRESENT must be ignored.
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      send(4'(i % 2)); send(iv); send(~iv);
      in_valid = 1'b1; in_data = 4'd7;
      tick();
      in_valid = 1'b0;
      if (i == 0) begin
        check("t5_first_txn", 32'(txn_cnt), 32'd1);
        check("t5_first_busy", 32'(busy), 32'd0);
      end
      if (i == 254) check("t5_txn_255", 32'(txn_cnt), 32'd255);
    end
    check("t5_wrap", 32'(txn_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check_bundle("t5_last", 4'd1, 4'd15, 4'd0);

    // Out-of-range opcode.
    send(4'd7);
`ifdef CUASI_OPCODE_CHECK_EN
    check("t6_err_pulse", 32'(err), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    tick();
    check("t6_err_clear", 32'(err), 32'd0);
    send(4'd1); send(4'd1); send(4'd1);
    check_bundle("t6_legal", 4'd1, 4'd1, 4'd1);
`else
    check("t6_err_zero", 32'(err), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    send(4'd1); send(4'd1);
    check("t6_valid", 32'(out_valid), 32'd1);
    check_bundle("t6_op7", 4'd7, 4'd1, 4'd1);
    check("t6_err_still_zero", 32'(err), 32'd0);
`endif
    tick();
    check("t6_txn", 32'(txn_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
